vga_timing_gen: RTL

Parametrised successor to the fixed 640x480@60 sync generator, used in the display path of the FPGA camera/plotter design.
- Generates h_sync, v_sync, data-enable and pixel coordinates for any timing set.
- Adds a pixel-clock-enable divider, configurable sync polarity, and a PIPE_DELAY alignment pipe so sync/DE line up with a downstream frame-buffer read of known latency.
- Adds line/frame/vblank strobes, a frame counter and a run/stop enable.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator.
// Produces pixel-tick, sync, data-enable and line/frame/vblank strobes for any
// timing set. Sync/DE/strobes pass through an alignment pipe of PIPE_DELAY
// pixel ticks, so x/y lead them and can serve as a frame-buffer fetch address.

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned H_FP            = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BP            = 48,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned V_FP            = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BP            = 33,
    parameter int unsigned SYNC_ACTIVE_LOW = 1,
    parameter int unsigned PIX_DIV         = 1,
    parameter int unsigned PIPE_DELAY      = 0,
    parameter int unsigned COORD_W         = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               pix_tick,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [COORD_W-1:0] x_pixel,
    output logic [COORD_W-1:0] y_pixel,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [15:0]        frame_count
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned V_SYNC_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int unsigned DIV_W        = 4;
    localparam int unsigned FC_W         = 16;
    localparam logic        SYNC_IDLE    = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // One alignment-pipe entry; hs/vs hold the output pin level directly.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
        logic vbs;
    } stage_t;

    localparam stage_t STAGE_IDLE = {1'b0, SYNC_IDLE, SYNC_IDLE, 3'b000};

    logic [DIV_W-1:0]   div_q;
    logic               div_last;
    logic [COORD_W-1:0] h_q;
    logic [COORD_W-1:0] v_q;
    logic               h_last;
    logic               v_last;
    stage_t             dec;
    stage_t             stg     [0:PIPE_DELAY];
    stage_t             pipe_in [0:PIPE_DELAY];

    assign div_last = (div_q == DIV_W'(PIX_DIV - 1));
    assign h_last   = (h_q == COORD_W'(H_TOTAL - 1));
    assign v_last   = (v_q == COORD_W'(V_TOTAL - 1));

    // Pixel-clock-enable divider; stopping rewinds it so restart is aligned.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_q    <= '0;
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= div_last;
            div_q    <= div_last ? '0 : div_q + DIV_W'(1);
        end
    end

    // Raster position, fetch coordinates and completed-frame count.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q         <= '0;
            v_q         <= '0;
            x_pixel     <= '0;
            y_pixel     <= '0;
            frame_count <= '0;
        end else if (!en) begin
            h_q     <= '0;
            v_q     <= '0;
            x_pixel <= '0;
            y_pixel <= '0;
        end else if (pix_tick) begin
            x_pixel <= h_q;
            y_pixel <= v_q;
            h_q     <= h_last ? '0 : h_q + COORD_W'(1);
            if (h_last) begin
                v_q <= v_last ? '0 : v_q + COORD_W'(1);
            end
            if (h_last && v_last) begin
                frame_count <= frame_count + FC_W'(1);
            end
        end
    end

    // Decode of the current raster position into pipe-entry form.
    always_comb begin
        dec     = STAGE_IDLE;
        dec.de  = (h_q < COORD_W'(H_ACTIVE)) && (v_q < COORD_W'(V_ACTIVE));
        dec.hs  = ((h_q >= COORD_W'(H_SYNC_FIRST)) && (h_q <= COORD_W'(H_SYNC_LAST)))
                  ? ~SYNC_IDLE : SYNC_IDLE;
        dec.vs  = ((v_q >= COORD_W'(V_SYNC_FIRST)) && (v_q <= COORD_W'(V_SYNC_LAST)))
                  ? ~SYNC_IDLE : SYNC_IDLE;
        dec.ls  = (h_q == '0);
        dec.fs  = (h_q == '0) && (v_q == '0);
        dec.vbs = (h_q == '0) && (v_q == COORD_W'(V_ACTIVE));
    end

    // Value each pipe stage loads on the next pixel tick.
    always_comb begin
        for (int unsigned i = 0; i <= PIPE_DELAY; i++) begin
            pipe_in[i] = STAGE_IDLE;
        end
        pipe_in[0] = dec;
        for (int unsigned i = 1; i <= PIPE_DELAY; i++) begin
            pipe_in[i] = stg[i-1];
        end
    end

    // Alignment pipe plus one-clk strobes marking what the final stage just took.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            for (int unsigned i = 0; i <= PIPE_DELAY; i++) begin
                stg[i] <= STAGE_IDLE;
            end
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            line_start   <= pix_tick && pipe_in[PIPE_DELAY].ls;
            frame_start  <= pix_tick && pipe_in[PIPE_DELAY].fs;
            vblank_start <= pix_tick && pipe_in[PIPE_DELAY].vbs;
            if (pix_tick) begin
                for (int unsigned i = 0; i <= PIPE_DELAY; i++) begin
                    stg[i] <= pipe_in[i];
                end
            end
        end
    end

    assign de     = stg[PIPE_DELAY].de;
    assign h_sync = stg[PIPE_DELAY].hs;
    assign v_sync = stg[PIPE_DELAY].vs;

endmodule
